// File: rtl/cpu_pkg.sv
// Shared widths, reset address, fetch state encoding and instruction field positions
// for the fetch stage and the blocks around it.
package cpu_pkg;
    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 11;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    localparam int INSTR_TYPE_BIT = 10;
    localparam int OPCODE_MSB     = 9;
    localparam int OPCODE_LSB     = 6;
    localparam int OP1_MSB        = 5;
    localparam int OP1_LSB        = 3;
    localparam int OP2_MSB        = 2;
    localparam int OP2_LSB        = 0;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decoder-side code port and control.
// master = the fetch unit; slave = memory/decoder/execute side.
interface fetch_unit_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic [INSTR_W-1:0] code;
    logic               code_valid;
    logic [ADDR_W-1:0]  code_pc;
    logic               halted;

    modport master (
        output imem_addr, code, code_valid, code_pc, halted,
        input  imem_rdata, stall, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_addr, code, code_valid, code_pc, halted,
        output imem_rdata, stall, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry skid buffer holding an instruction word and its address while the
// decoder is stalled. Flush wins over load; load wins over drain (replace).
module fetch_unit_skid #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_data,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_data,
    output logic [ADDR_W-1:0]  o_pc
);
    logic               r_valid;
    logic [INSTR_W-1:0] r_data;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequences the PC into a 1-cycle-latency instruction memory and
// delivers one word per cycle to the decoder, with redirect, stall and sticky halt.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_unit_if.master  bus
);
    fetch_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic               r_inflight_v, w_inflight_v_nxt;
    logic [ADDR_W-1:0]  r_inflight_pc, w_inflight_pc_nxt;
    logic [INSTR_W-1:0] r_code, w_code_nxt;
    logic               r_code_valid, w_code_valid_nxt;
    logic [ADDR_W-1:0]  r_code_pc, w_code_pc_nxt;
    logic               r_halted, w_halted_nxt;

    logic               w_skid_load, w_skid_drain, w_skid_flush;
    logic               w_skid_v;
    logic [INSTR_W-1:0] w_skid_data;
    logic [ADDR_W-1:0]  w_skid_pc;

    fetch_unit_skid #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_flush (w_skid_flush),
        .i_data  (bus.imem_rdata),
        .i_pc    (r_inflight_pc),
        .o_valid (w_skid_v),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= FS_BOOT;
            r_addr        <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
            r_code        <= '0;
            r_code_valid  <= 1'b0;
            r_code_pc     <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_inflight_v  <= w_inflight_v_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_code        <= w_code_nxt;
            r_code_valid  <= w_code_valid_nxt;
            r_code_pc     <= w_code_pc_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_inflight_v_nxt  = r_inflight_v;
        w_inflight_pc_nxt = r_inflight_pc;
        w_code_nxt        = r_code;
        w_code_valid_nxt  = r_code_valid;
        w_code_pc_nxt     = r_code_pc;
        w_halted_nxt      = r_halted;
        w_skid_load       = 1'b0;
        w_skid_drain      = 1'b0;
        w_skid_flush      = 1'b0;

        case (r_state)
            FS_BOOT: begin
                if (bus.halt) begin
                    w_state_nxt      = FS_HALT;
                    w_code_valid_nxt = 1'b0;
                    w_inflight_v_nxt = 1'b0;
                    w_skid_flush     = 1'b1;
                    w_halted_nxt     = 1'b1;
                end else begin
                    // RESET_PC is already on imem_addr, so its read is in flight now.
                    w_inflight_v_nxt  = 1'b1;
                    w_inflight_pc_nxt = r_addr;
                    w_addr_nxt        = r_addr + ADDR_W'(1);
                    w_state_nxt       = FS_RUN;
                end
            end
            FS_RUN: begin
                if (bus.halt) begin
                    w_state_nxt      = FS_HALT;
                    w_code_valid_nxt = 1'b0;
                    w_inflight_v_nxt = 1'b0;
                    w_skid_flush     = 1'b1;
                    w_halted_nxt     = 1'b1;
                end else if (bus.redirect) begin
                    w_code_valid_nxt = 1'b0;
                    w_inflight_v_nxt = 1'b0;
                    w_skid_flush     = 1'b1;
                    w_addr_nxt       = bus.redirect_pc;
                end else if (bus.stall) begin
                    // The address stays put, so the read data of an uncaptured
                    // in-flight word would be lost next cycle: park it in the skid.
                    if (r_inflight_v && !w_skid_v) begin
                        w_skid_load      = 1'b1;
                        w_inflight_v_nxt = 1'b0;
                    end
                end else if (w_skid_v) begin
                    w_code_nxt       = w_skid_data;
                    w_code_pc_nxt    = w_skid_pc;
                    w_code_valid_nxt = 1'b1;
                    if (r_inflight_v) begin
                        w_skid_load      = 1'b1;
                        w_inflight_v_nxt = 1'b0;
                    end else begin
                        // imem_addr has been re-read throughout the stall, so the
                        // next word can be issued now without a bubble.
                        w_skid_drain      = 1'b1;
                        w_inflight_v_nxt  = 1'b1;
                        w_inflight_pc_nxt = r_addr;
                        w_addr_nxt        = r_addr + ADDR_W'(1);
                    end
                end else begin
                    w_code_valid_nxt = r_inflight_v;
                    if (r_inflight_v) begin
                        w_code_nxt    = bus.imem_rdata;
                        w_code_pc_nxt = r_inflight_pc;
                    end
                    w_inflight_v_nxt  = 1'b1;
                    w_inflight_pc_nxt = r_addr;
                    w_addr_nxt        = r_addr + ADDR_W'(1);
                end
            end
            FS_HALT: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = FS_BOOT;
            end
        endcase
    end

    assign bus.imem_addr  = r_addr;
    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.code_pc    = r_code_pc;
    assign bus.halted     = r_halted;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/redirect traffic,
// compared every cycle against a delivery-level model of the fetch stream.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Instruction memory: word at address a is {3'b0, a}, one cycle read latency.
    always @(posedge clk) bus.imem_rdata <= INSTR_W'(bus.imem_addr);

    // Model: after reset one boot edge, then words are delivered in address order,
    // one per non-stalled edge once the pipe has refilled.
    logic       m_boot, m_halted, m_valid;
    logic [7:0] m_pc, m_next;
    int         m_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [7:0] rpc,
                        input logic h, input logic rs);
        rst             = rs;
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        bus.halt        = h;
        @(posedge clk);
        if (rs) begin
            m_boot = 1'b1; m_halted = 1'b0; m_valid = 1'b0;
            m_pc = 8'h00; m_next = RESET_PC; m_pending = 0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (h) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_pending = 1;
        end else if (r) begin
            m_valid = 1'b0; m_next = rpc; m_pending = 2;
        end else if (!s) begin
            if (m_pending > 1) begin
                m_pending--;
            end else begin
                m_pending = 0;
                m_valid   = 1'b1;
                m_pc      = m_next;
                m_next    = m_next + 8'd1;
            end
        end
        @(negedge clk);
        check("code_valid", 32'(bus.code_valid), 32'(m_valid));
        check("halted", 32'(bus.halted), 32'(m_halted));
        if (rs) begin
            check("reset_code", 32'(bus.code), 32'd0);
            check("reset_code_pc", 32'(bus.code_pc), 32'd0);
            check("reset_imem_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        end
        if (m_valid) begin
            check("code_pc", 32'(bus.code_pc), 32'(m_pc));
            check("code", 32'(bus.code), 32'({3'b000, m_pc}));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00; bus.halt = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // boot edge, then code_pc 0..5
        run(7);
        check("pc_before_stall", 32'(bus.code_pc), 32'h05);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run(3);
        check("pc_after_stall", 32'(bus.code_pc), 32'h08);

        run(8);
        check("pc_before_redirect", 32'(bus.code_pc), 32'h10);
        step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
        run(2);
        check("redirect_target", 32'(bus.code_pc), 32'h40);
        run(2);

        step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        run(2);
        check("redirect_over_stall", 32'(bus.code_pc), 32'h40);

        step(1'b0, 1'b1, 8'hF8, 1'b0, 1'b0);
        run(12);

        // stall right after redirect and right after boot-style refill
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run(1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run(3);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
                 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run(6);
        check("refetch_after_halt", 32'(bus.code_pc), 32'(RESET_PC + 8'd4));
        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 20) == 0),
                 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
